// File: rtl/serial_recv.sv
// 8N1 serial receiver: 2-flop synchronized line, mid-bit sampling, VALID/FRAME_ERR pulses.
// Latency falling edge -> VALID ~ 3 + ((WAIT_DIV-1)/2+1) + 9*WAIT_DIV cycles; no backpressure, bytes are never held off.
module serial_recv #(
  parameter int WAIT_DIV = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int CW = $clog2(WAIT_DIV);
  localparam logic [CW-1:0] LAST = CW'(WAIT_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'((WAIT_DIV - 1) / 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sr;
  logic          sync1;
  logic          rx_s;
  logic          rx_d;

  // Flops reset high so release into an idle line never looks like a falling edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= DATA_IN;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      sr        <= 8'h00;
      DATA_OUT  <= 8'h00;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= 3'd0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            sr  <= {rx_s, sr[7:1]};
            if (idx == 3'd7) state <= ST_STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              DATA_OUT <= sr;
              VALID    <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              FRAME_ERR <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // A line stuck low yields a single FRAME_ERR; wait for it to return high.
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_recv.sv
// Bench for serial_recv: scoreboard of expected bytes, one task per scenario.
module tb_serial_recv;

  localparam int W5 = 5;
  localparam int W8 = 8;

  logic       clk;
  logic       rst_n;
  logic       din5;
  logic       din8;
  logic [7:0] dout5;
  logic [7:0] dout8;
  logic       vld5;
  logic       vld8;
  logic       ferr5;
  logic       ferr8;
  logic       busy5;
  logic       busy8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int v5_cnt = 0;
  int fe5_cnt = 0;
  int v8_cnt = 0;
  int fe8_cnt = 0;
  int vld_cyc = 0;
  logic [7:0] exp_q[$];

  serial_recv #(.WAIT_DIV(W5)) u_dut5 (
    .CLK(clk), .RST(rst_n), .DATA_IN(din5),
    .DATA_OUT(dout5), .VALID(vld5), .FRAME_ERR(ferr5), .BUSY(busy5)
  );

  serial_recv #(.WAIT_DIV(W8)) u_dut8 (
    .CLK(clk), .RST(rst_n), .DATA_IN(din8),
    .DATA_OUT(dout8), .VALID(vld8), .FRAME_ERR(ferr8), .BUSY(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every VALID pops the oldest expected byte.
  always @(negedge clk) begin
    if (vld5) begin
      v5_cnt++;
      vld_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: got %02h, expected no byte", dout5);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout5 !== e) begin
          errors++;
          $display("FAIL sb_data: got %02h, expected %02h", dout5, e);
        end
      end
    end
    if (vld5 || ferr5) begin
      checks++;
      if (vld5 && ferr5) begin
        errors++;
        $display("FAIL pulse_exclusive: VALID=%b FRAME_ERR=%b, expected not both", vld5, ferr5);
      end
    end
    if (ferr5) fe5_cnt++;
    if (vld8) v8_cnt++;
    if (ferr8) fe8_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    din5 = 1'b0;
    repeat (W5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din5 = b[i];
      repeat (W5) @(negedge clk);
    end
    din5 = stop_bit;
    repeat (W5) @(negedge clk);
    din5 = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 * W5; i++) begin
      @(negedge clk);
      if (!busy5 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    din5 = 1'b1;
    din8 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dout5 !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", dout5); end
    checks++; if (vld5 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", vld5); end
    checks++; if (ferr5 !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, expected 0", ferr5); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy5); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL idle_after_reset: BUSY got %b, expected 0", busy5); end
  endtask

  task automatic test_single;
    bit ok;
    int v0, f0, t0, lat;
    v0 = v5_cnt; f0 = fe5_cnt;
    exp_q.push_back(8'h41);
    t0 = cyc;
    send_byte(8'h41, 1'b1);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: frame not completed, expected VALID"); end
    checks++; if (v5_cnt - v0 !== 1) begin errors++; $display("FAIL single_valid_count: got %0d, expected 1", v5_cnt - v0); end
    checks++; if (fe5_cnt - f0 !== 0) begin errors++; $display("FAIL single_ferr: got %0d, expected 0", fe5_cnt - f0); end
    checks++; if (dout5 !== 8'h41) begin errors++; $display("FAIL single_data: got %02h, expected 41", dout5); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, expected 0", busy5); end
    lat = vld_cyc - t0;
    checks++;
    if (lat < 3 + (W5 - 1) / 2 + 1 + 9 * W5 - 1 || lat > 3 + (W5 - 1) / 2 + 1 + 9 * W5 + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles, expected %0d +/-1", lat, 3 + (W5 - 1) / 2 + 1 + 9 * W5);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int v0, f0;
    v0 = v5_cnt; f0 = fe5_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA5);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    send_byte(8'hA5, 1'b1);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: %0d bytes outstanding, expected 0", exp_q.size()); end
    checks++; if (v5_cnt - v0 !== 3) begin errors++; $display("FAIL b2b_valid_count: got %0d, expected 3", v5_cnt - v0); end
    checks++; if (fe5_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d, expected 0", fe5_cnt - f0); end
    checks++; if (dout5 !== 8'hA5) begin errors++; $display("FAIL b2b_last_data: got %02h, expected A5", dout5); end
  endtask

  task automatic test_glitch;
    bit seen_busy;
    seen_busy = 1'b0;
    @(negedge clk);
    din8 = 1'b0;
    @(negedge clk);
    din8 = 1'b1;
    for (int i = 0; i < 4 * W8; i++) begin
      @(negedge clk);
      if (busy8) seen_busy = 1'b1;
    end
    checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: BUSY never high, expected a pulse"); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b, expected 0", busy8); end
    checks++; if (v8_cnt !== 0) begin errors++; $display("FAIL glitch_valid: got %0d pulses, expected 0", v8_cnt); end
    checks++; if (fe8_cnt !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses, expected 0", fe8_cnt); end
    checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL glitch_data: got %02h, expected 00", dout8); end
  endtask

  task automatic test_frame_err;
    bit ok;
    int v0, f0;
    v0 = v5_cnt; f0 = fe5_cnt;
    send_byte(8'h55, 1'b0);
    din5 = 1'b0;
    repeat (30 * W5) @(negedge clk);
    checks++; if (fe5_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d, expected 1", fe5_cnt - f0); end
    checks++; if (busy5 !== 1'b1) begin errors++; $display("FAIL ferr_busy_held: got %b, expected 1", busy5); end
    checks++; if (dout5 !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %02h, expected A5", dout5); end
    checks++; if (v5_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d, expected 0", v5_cnt - v0); end
    din5 = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b, expected 0", busy5); end
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ferr_recover_timeout: 3C not received, expected VALID"); end
    checks++; if (dout5 !== 8'h3C) begin errors++; $display("FAIL ferr_recover_data: got %02h, expected 3C", dout5); end
    checks++; if (fe5_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_recover_count: got %0d, expected 1", fe5_cnt - f0); end
  endtask

  task automatic test_async_reset;
    bit ok;
    int v0, f0;
    v0 = v5_cnt; f0 = fe5_cnt;
    fork
      send_byte(8'hC3, 1'b1);
      begin
        repeat (4 * W5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dout5 !== 8'h00) begin errors++; $display("FAIL arst_data: got %02h, expected 00", dout5); end
        checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b, expected 0", busy5); end
        checks++; if (vld5 !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, expected 0", vld5); end
        checks++; if (ferr5 !== 1'b0) begin errors++; $display("FAIL arst_ferr: got %b, expected 0", ferr5); end
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * W5) @(negedge clk);
    checks++; if (v5_cnt - v0 !== 0) begin errors++; $display("FAIL arst_no_valid: got %0d, expected 0", v5_cnt - v0); end
    checks++; if (fe5_cnt - f0 !== 0) begin errors++; $display("FAIL arst_no_ferr: got %0d, expected 0", fe5_cnt - f0); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL arst_idle: BUSY got %b, expected 0", busy5); end
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL arst_next_timeout: 81 not received, expected VALID"); end
    checks++; if (dout5 !== 8'h81) begin errors++; $display("FAIL arst_next_data: got %02h, expected 81", dout5); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d bytes never received, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
